// File: rtl/mem_pkg.sv
// Shared types and constants for the block memory controller and its storage array.
package mem_pkg;

    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned BLOCK_IDX_W     = 6;
    localparam int unsigned OFFSET_W        = 4;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned BLOCK_BITS      = WORDS_PER_BLOCK * WORD_W;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    typedef struct packed {
        logic                   we;
        logic [BLOCK_IDX_W-1:0] blk_idx;
        logic [BLOCK_BITS-1:0]  wdata;
    } req_t;

endpackage

// File: rtl/block_mem_ctrl_if.sv
// Request/response bus between the write-back cache and the block memory controller.
// resp_err exists only when MEM_ALIGN_CHECK_EN is defined.
interface block_mem_ctrl_if #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned BLOCK_W = 128
) ();

    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [ADDR_W-1:0]  req_addr;
    logic [BLOCK_W-1:0] req_wdata;
    logic               resp_valid;
    logic [BLOCK_W-1:0] resp_rdata;
`ifdef MEM_ALIGN_CHECK_EN
    logic               resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
`else
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
`endif

endinterface

// File: rtl/mem_block_array.sv
// 64 x 128 block storage: synchronous write, registered read, not cleared by reset.
// Simulation power-up contents: word i holds the value i.
module mem_block_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 128
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [BLOCK_IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic [BLOCK_IDX_W-1:0] raddr,
    output logic [WIDTH-1:0]       rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    initial begin
        for (int unsigned b = 0; b < DEPTH; b++) begin
            for (int unsigned w = 0; w < WORDS_PER_BLOCK; w++) begin
                mem[b][w*WORD_W +: WORD_W] = WORD_W'(b * WORDS_PER_BLOCK + w);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/block_mem_ctrl.sv
// Multi-cycle whole-block memory stage behind the write-back cache (IDLE -> WAIT -> DONE).
// Optional MEM_ALIGN_CHECK_EN: misaligned requests commit nothing and pulse resp_err.
module block_mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned BLOCK_W = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    block_mem_ctrl_if.slave  bus
);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    req_t                   req_q;
    logic [BLOCK_W-1:0]     resp_rdata_q;
    logic [BLOCK_W-1:0]     arr_rdata;
    logic [BLOCK_IDX_W-1:0] req_idx;
    logic [BLOCK_IDX_W-1:0] rd_idx;
    logic                   accept;
    logic                   commit;
    logic                   commit_ok;
    logic                   wr_en;

    assign req_idx = bus.req_addr[ADDR_W-1 -: BLOCK_IDX_W];

    // The read port is registered, so while idle it already looks up the incoming index;
    // this keeps the array output valid at the commit edge even when LATENCY is 1.
    assign rd_idx = (state_q == IDLE) ? req_idx : req_q.blk_idx;

`ifdef MEM_ALIGN_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= |bus.req_addr[OFFSET_W-1:0];
        end
    end

    assign commit_ok    = commit && !err_q;
    assign bus.resp_err = (state_q == DONE) && err_q;
`else
    logic unused_offset;

    // Raw CPU addresses arrive here; the byte offset carries no meaning for block access.
    assign unused_offset = ^bus.req_addr[OFFSET_W-1:0];
    assign commit_ok     = commit;
`endif

    assign wr_en = commit_ok && req_q.we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        accept         = 1'b0;
        commit         = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    commit  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.resp_valid = 1'b1;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q        <= '0;
            resp_rdata_q <= '0;
        end else begin
            if (accept) begin
                req_q.we      <= bus.req_we;
                req_q.blk_idx <= req_idx;
                req_q.wdata   <= bus.req_wdata;
            end
            if (commit_ok && !req_q.we) begin
                resp_rdata_q <= arr_rdata;
            end
        end
    end

    assign bus.resp_rdata = resp_rdata_q;

    mem_block_array #(
        .DEPTH (64),
        .WIDTH (BLOCK_W)
    ) u_array (
        .clk   (clk),
        .we    (wr_en),
        .waddr (req_q.blk_idx),
        .wdata (req_q.wdata),
        .raddr (rd_idx),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_block_mem_ctrl.sv
// Scoreboard bench for block_mem_ctrl: LATENCY=4 instance with random traffic, LATENCY=1 corner instance.
module tb_block_mem_ctrl;

    localparam int LAT_A = 4;
    localparam int LAT_B = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    block_mem_ctrl_if #(.ADDR_W(10), .BLOCK_W(128)) bus_a ();
    block_mem_ctrl_if #(.ADDR_W(10), .BLOCK_W(128)) bus_b ();

    block_mem_ctrl #(.LATENCY(LAT_A), .ADDR_W(10), .BLOCK_W(128)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    block_mem_ctrl #(.LATENCY(LAT_B), .ADDR_W(10), .BLOCK_W(128)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    int          edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference memory: word i of the 1 KB space, power-up value i.
    logic [31:0]  model [256];
    logic [127:0] last_rd_a;

    typedef struct {
        bit           we;
        bit           err;
        logic [127:0] rdata;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   pulses_a = 0;
    int   issued_a = 0;
    bit   prev_valid_a = 1'b0;

    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_blk(input int b);
        logic [127:0] r;
        for (int n = 0; n < 4; n++) r[32*n +: 32] = model[4*b + n];
        return r;
    endfunction

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (bus_a.resp_valid === 1'b1) begin
            pulses_a++;
            check_eq("a_pulse_width", 128'(prev_valid_a), 128'd0);
            if (sb.size() == 0) begin
                check_eq("a_unexpected_resp", 128'd1, 128'd0);
            end else begin
                e = sb.pop_front();
                check_eq("a_resp_time", 128'(edge_cnt), 128'(e.due));
                check_eq("a_resp_rdata", bus_a.resp_rdata, e.rdata);
`ifdef MEM_ALIGN_CHECK_EN
                check_eq("a_resp_err", 128'(bus_a.resp_err), 128'(e.err));
`endif
            end
        end else if (sb.size() != 0) begin
            check_eq("a_ready_busy", 128'(bus_a.req_ready), 128'd0);
        end
        prev_valid_a = (bus_a.resp_valid === 1'b1);
    end

    task automatic wait_ready_a();
        int guard = 0;
        while (bus_a.req_ready !== 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 50) begin
                errors++;
                $display("FAIL a_accept_timeout: got ready=%b expected 1", bus_a.req_ready);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $fatal(1, "accept timeout");
            end
        end
    endtask

    task automatic req_a(input bit we, input logic [9:0] addr, input logic [127:0] wd,
                         input bit hold, output int acc);
        exp_t e;
        int   b;
        @(negedge clk);
        bus_a.req_valid = 1'b1;
        bus_a.req_we    = we;
        bus_a.req_addr  = addr;
        bus_a.req_wdata = wd;
        wait_ready_a();
        @(posedge clk);
        #1;
        acc   = edge_cnt;
        b     = int'(addr[9:4]);
        e.we  = we;
        e.due = acc + LAT_A;
`ifdef MEM_ALIGN_CHECK_EN
        e.err = (addr[3:0] != 4'd0);
`else
        e.err = 1'b0;
`endif
        if (e.err) begin
            e.rdata = last_rd_a;
        end else if (we) begin
            for (int n = 0; n < 4; n++) model[4*b + n] = wd[32*n +: 32];
            e.rdata = last_rd_a;
        end else begin
            e.rdata   = model_blk(b);
            last_rd_a = e.rdata;
        end
        sb.push_back(e);
        issued_a++;
        if (!hold) bus_a.req_valid = 1'b0;
        // Scramble the request fields: they must be ignored after the accept edge.
        bus_a.req_we    = 1'($urandom);
        bus_a.req_addr  = 10'($urandom);
        bus_a.req_wdata = rand_blk();
    endtask

    task automatic drain_a();
        int guard = 0;
        while (sb.size() != 0) begin
            @(negedge clk);
            guard++;
            if (guard > 100) begin
                errors++;
                $display("FAIL a_drain_timeout: got %0d pending expected 0", sb.size());
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $fatal(1, "drain timeout");
            end
        end
        @(negedge clk);
    endtask

    task automatic op_b(input bit we, input logic [9:0] addr, input logic [127:0] wd,
                        input logic [127:0] exp_rd);
        int guard = 0;
        @(negedge clk);
        bus_b.req_valid = 1'b1;
        bus_b.req_we    = we;
        bus_b.req_addr  = addr;
        bus_b.req_wdata = wd;
        while (bus_b.req_ready !== 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 20) begin
                errors++;
                $display("FAIL b_accept_timeout: got ready=%b expected 1", bus_b.req_ready);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $fatal(1, "accept timeout");
            end
        end
        @(posedge clk);
        #1;
        bus_b.req_valid = 1'b0;
        bus_b.req_wdata = rand_blk();
        @(negedge clk);
        check_eq("b_wait_valid", 128'(bus_b.resp_valid), 128'd0);
        check_eq("b_wait_ready", 128'(bus_b.req_ready), 128'd0);
        @(negedge clk);
        check_eq("b_done_valid", 128'(bus_b.resp_valid), 128'd1);
        check_eq("b_done_rdata", bus_b.resp_rdata, exp_rd);
`ifdef MEM_ALIGN_CHECK_EN
        check_eq("b_done_err", 128'(bus_b.resp_err), 128'd0);
`endif
        @(negedge clk);
        check_eq("b_after_valid", 128'(bus_b.resp_valid), 128'd0);
        check_eq("b_after_ready", 128'(bus_b.req_ready), 128'd1);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int           k1, k2;
        logic [127:0] wd, rd_b;
        logic [9:0]   addr;
        int           guard;

        for (int i = 0; i < 256; i++) model[i] = 32'(i);
        last_rd_a = '0;
        bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
        bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0; bus_b.req_wdata = '0;

        #12;
        check_eq("a_rst_ready", 128'(bus_a.req_ready), 128'd1);
        check_eq("a_rst_valid", 128'(bus_a.resp_valid), 128'd0);
        check_eq("a_rst_rdata", bus_a.resp_rdata, 128'd0);
        check_eq("b_rst_ready", 128'(bus_b.req_ready), 128'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Read of block 4 straight after reset.
        req_a(1'b0, 10'h040, '0, 1'b0, k1);
        drain_a();
        check_eq("a_first_read", bus_a.resp_rdata, {32'h13, 32'h12, 32'h11, 32'h10});

        // Write block 63, then read it back through a different byte offset.
        wd = {32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
        req_a(1'b1, 10'h3F0, wd, 1'b0, k1);
        drain_a();
        req_a(1'b0, 10'h3FC, '0, 1'b0, k1);
        drain_a();

        // Backpressure: second request held valid across WAIT/DONE.
        req_a(1'b0, 10'h080, '0, 1'b1, k1);
        req_a(1'b1, 10'h0C0, rand_blk(), 1'b0, k2);
        check_eq("a_bp_accept_gap", 128'(k2 - k1), 128'(LAT_A + 2));
        drain_a();
        check_eq("a_bp_pulses", 128'(pulses_a), 128'(issued_a));

        // Reset two cycles after accepting a write, before its commit edge.
        @(negedge clk);
        bus_a.req_valid = 1'b1;
        bus_a.req_we    = 1'b1;
        bus_a.req_addr  = 10'h080;
        bus_a.req_wdata = rand_blk();
        wait_ready_a();
        @(posedge clk);
        #1;
        bus_a.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("a_midrst_ready", 128'(bus_a.req_ready), 128'd1);
        check_eq("a_midrst_valid", 128'(bus_a.resp_valid), 128'd0);
        check_eq("a_midrst_rdata", bus_a.resp_rdata, 128'd0);
        last_rd_a = '0;
        @(negedge clk);
        rst_n = 1'b1;
        req_a(1'b0, 10'h080, '0, 1'b0, k1);
        drain_a();

        // Byte-offset write to block 4, then read the block.
        req_a(1'b1, 10'h044, rand_blk(), 1'b0, k1);
        drain_a();
        req_a(1'b0, 10'h040, '0, 1'b0, k1);
        drain_a();

        // Random traffic over a few blocks so reads frequently hit recent writes.
        for (int i = 0; i < 40; i++) begin
            addr[9:4] = ($urandom_range(0, 5) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
`ifdef MEM_ALIGN_CHECK_EN
            addr[3:0] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
`else
            addr[3:0] = 4'($urandom);
`endif
            req_a(1'($urandom), addr, rand_blk(), (i != 39) && ($urandom_range(0, 1) == 1), k1);
        end
        drain_a();
        check_eq("a_total_pulses", 128'(pulses_a), 128'(issued_a));

        // LATENCY = 1 instance.
        rd_b = {32'h13, 32'h12, 32'h11, 32'h10};
        op_b(1'b0, 10'h040, '0, rd_b);
        wd = rand_blk();
        op_b(1'b1, 10'h020, wd, rd_b);
        op_b(1'b0, 10'h020, '0, wd);
        op_b(1'b0, 10'h3F0, '0, {32'hFF, 32'hFE, 32'hFD, 32'hFC});

        guard = 0;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/block_mem_ctrl.md
Name: block_mem_ctrl

Overview:
- Multi-cycle main-memory stage directly downstream of the direct-mapped write-back cache.
- Serves whole-block (4 x 32-bit = 128-bit) refills and dirty write-backs over a valid/ready request and a one-cycle response pulse.
- Replaces the zero-latency memory model so that cache miss latency is real and can be measured.
- Address space: 10-bit byte address, 1 KB, 64 blocks of 16 bytes.

Parameters:
- LATENCY, 4, cycles from request accept to response (legal range 1..15).
- ADDR_W, 10, byte-address width.
- BLOCK_W, 128, block width in bits (fixed at 4 words).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  0 = block read (refill), 1 = block write (write-back).
- req_addr  in  ADDR_W  byte address; bits [3:0] ignored, block index = req_addr[9:4].
- req_wdata  in  BLOCK_W  write block; word n is bits [32n+31:32n].
- resp_valid  out  1  one-cycle completion pulse (reads and writes).
- resp_rdata  out  BLOCK_W  read block, valid while resp_valid = 1.
- resp_err  out  1  only present with MEM_ALIGN_CHECK_EN.

Behaviour:
- Reset values: req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, state = IDLE, cnt = 0.
- Storage is not cleared by rst_n. Simulation power-up contents: word i (0..255) holds 32'hi.
- FSM states:
  - IDLE: req_ready = 1. On req_valid at a rising edge, latch we, addr[9:4] and wdata, load cnt = LATENCY-1, go to WAIT.
  - WAIT: req_ready = 0. Each edge with cnt != 0 decrements cnt. At the edge where cnt == 0, commit the access: on a write, update the array; on a read, capture the block into resp_rdata. Same edge sets resp_valid = 1 and goes to DONE.
  - DONE: req_ready = 0, resp_valid = 1 for exactly this cycle. Next edge clears resp_valid and returns to IDLE.
- Latency: accept at edge k; resp_valid is high during the cycle after edge k+LATENCY. Next accept is possible at edge k+LATENCY+2 at the earliest.
- Request inputs are sampled only at the accept edge. Changes afterwards have no effect.
- On a write, resp_rdata holds its previous value.
- A read at the block just written (after the write's DONE) returns the new data. There is no bypass path because requests never overlap.
- req_valid while req_ready = 0 is ignored. The requester holds it until accepted.
- Reset mid-operation:
  - Before the commit edge: the access is aborted, memory is unchanged, no response is given.
  - After the commit edge: the write persists.
- Address wrap: block index is addr[9:4] modulo 64. There is no out-of-range case.
- LATENCY = 1: WAIT lasts one cycle.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Port resp_err exists.
  - A request with req_addr[3:0] != 0 still runs the full LATENCY timing but commits nothing (no write, resp_rdata unchanged) and pulses resp_err together with resp_valid.
- Undefined:
  - No resp_err port.
  - Low address bits are silently ignored, since the cache issues raw CPU addresses.

Decomposition:
- Shared package mem_pkg:
  - Constants WORDS_PER_BLOCK = 4, BLOCK_IDX_W = 6, OFFSET_W = 4.
  - State enum {IDLE, WAIT, DONE}.
  - Request struct {we, blk_idx, wdata}.
- One sub-module, mem_block_array: a 64 x 128 synchronous storage array with a write-enable port and a registered read port, plus the power-up initial block.
- The FSM and counter stay in block_mem_ctrl.

Test Plan:
- Read after reset: LATENCY=4, accept read addr 10'h040 at edge 0 -> resp_valid only in the cycle after edge 4; resp_rdata = {32'h13, 32'h12, 32'h11, 32'h10}.
- Write then read: write addr 10'h3F0 with data {A,B,C,D}; after DONE, read 10'h3FC -> resp_rdata = {A,B,C,D}. Also check req_ready = 0 throughout both WAIT periods.
- Backpressure: hold req_valid high with a second request during WAIT/DONE -> only one accept; the second is accepted at edge k+LATENCY+2; exactly 2 resp_valid pulses in total.
- Reset mid-write: assert rst_n low 2 cycles after accepting a write to 10'h080 (LATENCY=4) -> outputs return to reset values asynchronously; a later read of 10'h080 returns the original {32'h23..32'h20}.
- LATENCY=1 corner: accept at edge k -> resp_valid high exactly one cycle after edge k+1; resp_valid never high for two consecutive cycles.
- With MEM_ALIGN_CHECK_EN: write to 10'h044 -> resp_err = resp_valid = 1 for one cycle; block 4 is unchanged. Without the macro, the same write updates block 4.
